temp_level_sampler: RTL and testbench

- Upstream stage of the desorption PWM heater controller.
- Periodically reads the heater temperature from an external 3-wire serial ADC (CS, SCLK, MISO), quantizes the reading into the 2-bit measured temperature level with hysteresis, and presents it on `state_bits_o`.
- `state_bits_o` feeds the PWM stage's `state_bits` input directly.

---
 rtl/temp_level_sampler_if.sv | 19 +
 rtl/temp_level_sampler.sv | 186 ++++++++++++++++++
 tb/tb_temp_level_sampler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/temp_level_sampler_if.sv
// temp_level_sampler_if: 3-wire serial ADC bus (chip select, serial clock, data in).
// master = sampler side driving CS/SCLK, slave = ADC side driving MISO.
interface temp_level_sampler_if;
   logic adc_cs_no;
   logic adc_sclk_o;
   logic adc_miso_i;

   modport master (
      output adc_cs_no,
      output adc_sclk_o,
      input  adc_miso_i
   );

   modport slave (
      input  adc_cs_no,
      input  adc_sclk_o,
      output adc_miso_i
   );
endinterface

// File: rtl/temp_level_sampler.sv
// temp_level_sampler: periodic serial-ADC reader feeding a hysteretic 2-bit temperature level.
// Optional build macro MEDIAN_FILTER_EN enables a 3-tap median over recent raw samples.
module temp_level_sampler #(
   parameter int unsigned CLK_DIV       = 2,
   parameter int unsigned SAMPLE_PERIOD = 64,
   parameter int unsigned LEAD_BITS     = 3,
   parameter int unsigned ADC_BITS      = 10,
   parameter int unsigned TH1           = 256,
   parameter int unsigned TH2           = 512,
   parameter int unsigned TH3           = 768,
   parameter int unsigned HYST          = 16
) (
   input  logic                      clk,
   input  logic                      rst_i,
   input  logic                      en_i,
   temp_level_sampler_if.master      adc,
   output logic [ADC_BITS-1:0]       sample_o,
   output logic [1:0]                state_bits_o,
   output logic                      valid_o
);

   localparam int unsigned N_BITS = LEAD_BITS + ADC_BITS;
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TMR_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned HALF_W = $clog2(2 * N_BITS);
   localparam int unsigned QW     = ADC_BITS + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * N_BITS - 1);
   localparam logic [QW-1:0]     TH1_Q     = QW'(TH1);
   localparam logic [QW-1:0]     TH2_Q     = QW'(TH2);
   localparam logic [QW-1:0]     TH3_Q     = QW'(TH3);
   localparam logic [QW-1:0]     HYST_Q    = QW'(HYST);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_DONE
   } state_e;

   state_e              state;
   logic [TMR_W-1:0]    tmr;
   logic                tick;
   logic [DIV_W-1:0]    div_cnt;
   logic                div_last;
   logic [HALF_W-1:0]   half_cnt;
   logic                cs_n_q;
   logic                sclk_q;
   logic [ADC_BITS-1:0] shreg;
   logic [ADC_BITS-1:0] filt;
   logic [QW-1:0]       q_s;
   logic [QW-1:0]       q_sh;
   logic [1:0]          up_lvl;
   logic [1:0]          dn_lvl;
   logic [1:0]          next_lvl;

   assign adc.adc_cs_no  = cs_n_q;
   assign adc.adc_sclk_o = sclk_q;

   // Tick is only consumed in IDLE; a tick landing mid-frame is simply lost.
   assign tick     = en_i && (tmr == TMR_LAST);
   assign div_last = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst_i || !en_i) begin
         tmr <= '0;
      end else if (tick) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + TMR_W'(1);
      end
   end

`ifdef MEDIAN_FILTER_EN
   logic [ADC_BITS-1:0] hist1;
   logic [ADC_BITS-1:0] hist2;

   function automatic logic [ADC_BITS-1:0] med3(input logic [ADC_BITS-1:0] a,
                                                input logic [ADC_BITS-1:0] b,
                                                input logic [ADC_BITS-1:0] c);
      logic [ADC_BITS-1:0] lo;
      logic [ADC_BITS-1:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c <= lo)      return lo;
      else if (c >= hi) return hi;
      else              return c;
   endfunction

   assign filt = med3(shreg, hist1, hist2);

   always_ff @(posedge clk) begin
      if (rst_i) begin
         hist1 <= '0;
         hist2 <= '0;
      end else if (state == ST_SHIFT && div_last && half_cnt == HALF_LAST) begin
         hist1 <= shreg;
         hist2 <= hist1;
      end
   end
`else
   assign filt = shreg;
`endif

   // Widened by one bit so adding the hysteresis margin cannot wrap.
   always_comb begin
      q_s      = {1'b0, filt};
      q_sh     = q_s + HYST_Q;
      up_lvl   = {1'b0, q_s >= TH1_Q} + {1'b0, q_s >= TH2_Q} + {1'b0, q_s >= TH3_Q};
      dn_lvl   = {1'b0, q_sh >= TH1_Q} + {1'b0, q_sh >= TH2_Q} + {1'b0, q_sh >= TH3_Q};
      next_lvl = state_bits_o;
      if (up_lvl > state_bits_o) begin
         next_lvl = up_lvl;
      end else if (dn_lvl < state_bits_o) begin
         next_lvl = dn_lvl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         div_cnt      <= '0;
         half_cnt     <= '0;
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b0;
         shreg        <= '0;
         sample_o     <= '0;
         state_bits_o <= '0;
         valid_o      <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  state    <= ST_SETUP;
                  cs_n_q   <= 1'b0;
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  shreg    <= '0;
               end
            end
            ST_SETUP: begin
               if (div_last) begin
                  state   <= ST_SHIFT;
                  div_cnt <= '0;
                  sclk_q  <= 1'b1;
                  shreg   <= {shreg[ADC_BITS-2:0], adc.adc_miso_i};
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_SHIFT: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (half_cnt == HALF_LAST) begin
                     // Final low half-period has elapsed: publish in the cycle CS rises.
                     state        <= ST_DONE;
                     cs_n_q       <= 1'b1;
                     valid_o      <= 1'b1;
                     sample_o     <= filt;
                     state_bits_o <= next_lvl;
                  end else begin
                     half_cnt <= half_cnt + HALF_W'(1);
                     sclk_q   <= ~sclk_q;
                     // Leading bits fall off the top of the register as data arrives.
                     if (!sclk_q) begin
                        shreg <= {shreg[ADC_BITS-2:0], adc.adc_miso_i};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_level_sampler.sv
// tb_temp_level_sampler: directed frames through a serial ADC model; a scoreboard queue
// holds expected sample/level pairs that a monitor pops on every valid_o pulse.
module tb_temp_level_sampler;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic [9:0] sample_o;
   logic [1:0] state_bits_o;
   logic       valid_o;

   temp_level_sampler_if adc_bus();

   temp_level_sampler #(
      .CLK_DIV(2), .SAMPLE_PERIOD(64), .LEAD_BITS(3), .ADC_BITS(10),
      .TH1(256), .TH2(512), .TH3(768), .HYST(16)
   ) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .adc          (adc_bus),
      .sample_o     (sample_o),
      .state_bits_o (state_bits_o),
      .valid_o      (valid_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] smp;
      logic [1:0] lvl;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   // ADC model: lead bits 101 then the 10-bit value, next bit presented after each SCLK fall.
   logic [9:0]  adc_val = '0;
   logic [12:0] adc_word;
   int          adc_bit = 0;
   assign adc_word = {3'b101, adc_val};
   always @(negedge adc_bus.adc_sclk_o or posedge adc_bus.adc_cs_no) begin
      if (adc_bus.adc_cs_no === 1'b1) adc_bit = 0;
      else                            adc_bit = adc_bit + 1;
   end
   assign adc_bus.adc_miso_i = (adc_bit < 13) ? adc_word[12 - adc_bit] : 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic expect_frame(input int val, input int smp, input int lvl);
      exp_t e;
      adc_val = 10'(val);
      e.smp   = 10'(smp);
      e.lvl   = 2'(lvl);
      sb_q.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (valid_o !== 1'b1 && k < 200);
      check({name, "_valid"}, (valid_o === 1'b1) ? 1 : 0, 1);
   endtask

   task automatic wait_cs_low(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (adc_bus.adc_cs_no !== 1'b0 && k < 300);
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_o === 1'b1) begin
            check("valid_expected", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("sample", sample_o, e.smp);
               check("state_bits", state_bits_o, e.lvl);
            end
         end
      end
   end

   int   n;
   int   low;
   int   pulses;
   int   rises;
   int   vcnt;
   int   busy;
   logic prev;

`ifdef MEDIAN_FILTER_EN
   int seq_raw [4] = '{500, 900, 510, 520};
   int seq_smp [4] = '{0, 500, 510, 520};
   int seq_lvl [4] = '{0, 1, 1, 1};
`else
   int seq_raw [9] = '{700, 760, 768, 760, 752, 751, 0, 1000, 0};
   int seq_smp [9] = '{700, 760, 768, 760, 752, 751, 0, 1000, 0};
   int seq_lvl [9] = '{2, 2, 3, 3, 3, 2, 0, 3, 0};
`endif

   initial begin
      rst_i = 1'b1;
      en_i  = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_cs_n", adc_bus.adc_cs_no, 1);
      check("rst_sclk", adc_bus.adc_sclk_o, 0);
      check("rst_valid", valid_o, 0);

      // Frame timing with 677 on the ADC.
`ifdef MEDIAN_FILTER_EN
      expect_frame(677, 0, 0);
`else
      expect_frame(677, 677, 2);
`endif
      rst_i = 1'b0;
      en_i  = 1'b1;
      wait_cs_low(n);
      check("first_start_latency", n, 64);
      low = 0; pulses = 0; prev = 1'b0;
      while (adc_bus.adc_cs_no === 1'b0 && low < 200) begin
         low++;
         if (adc_bus.adc_sclk_o === 1'b1 && prev === 1'b0) pulses++;
         prev = adc_bus.adc_sclk_o;
         @(negedge clk);
      end
      check("cs_low_cycles", low, 54);
      check("sclk_pulses", pulses, 13);
      check("valid_when_cs_rises", (valid_o === 1'b1) ? 1 : 0, 1);
      wait_cs_low(n);
      check("tick_period", low + n, 64);

      // Reset at the sixth SCLK rise of this (unexpected) frame.
      rises = 0; n = 0; prev = adc_bus.adc_sclk_o;
      while (rises < 6 && n < 300) begin
         @(negedge clk);
         n++;
         if (adc_bus.adc_sclk_o === 1'b1 && prev === 1'b0) rises++;
         prev = adc_bus.adc_sclk_o;
      end
      check("reach_bit6", rises, 6);
      rst_i = 1'b1;
      @(negedge clk);
      check("midrst_cs_n", adc_bus.adc_cs_no, 1);
      check("midrst_sclk", adc_bus.adc_sclk_o, 0);
      check("midrst_sample", sample_o, 0);
      check("midrst_state_bits", state_bits_o, 0);
      check("midrst_valid", valid_o, 0);
      rst_i = 1'b0;
      expect_frame(seq_raw[0], seq_smp[0], seq_lvl[0]);
      n = 0; vcnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (valid_o === 1'b1) vcnt++;
      end while (adc_bus.adc_cs_no !== 1'b0 && n < 300);
      check("restart_latency", n, 64);
      check("no_valid_after_reset", vcnt, 0);
      wait_valid("seq0");

      // Directed sequence: hysteresis and multi-level jumps (or median filter build).
      for (int i = 1; i < $size(seq_raw); i++) begin
         expect_frame(seq_raw[i], seq_smp[i], seq_lvl[i]);
         wait_valid("seq");
      end

      // Drop enable mid-frame: frame publishes, then the bus stays idle.
`ifdef MEDIAN_FILTER_EN
      expect_frame(600, 520, 1);
`else
      expect_frame(600, 600, 2);
`endif
      wait_cs_low(n);
      repeat (20) @(negedge clk);
      en_i = 1'b0;
      wait_valid("en_drop");
      busy = 0;
      repeat (150) begin
         @(negedge clk);
         if (adc_bus.adc_cs_no !== 1'b1 || adc_bus.adc_sclk_o !== 1'b0) busy++;
      end
      check("idle_bus_while_disabled", busy, 0);
`ifdef MEDIAN_FILTER_EN
      expect_frame(100, 520, 1);
`else
      expect_frame(100, 100, 0);
`endif
      en_i = 1'b1;
      wait_cs_low(n);
      check("reenable_latency", n, 64);
      wait_valid("reenable");

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
